// File: rtl/conv_encoder_serializer_if.sv
// Byte-in / symbol-out bundle between the whitening stage, the encoder and the interleaver.
interface conv_encoder_serializer_if;
    logic [7:0] din;
    logic       indicator;
    logic [1:0] dout;
    logic       dout_valid;
    logic       next_indicator;

    modport master (output din, indicator, input dout, dout_valid, next_indicator);
    modport slave  (input din, indicator, output dout, dout_valid, next_indicator);
endinterface

// File: rtl/conv_encoder_serializer.sv
// LSB-first serializer + rate-1/2 K=7 convolutional encoder (133/171), 6 zero tail bits per frame.
// Latency: 1 clk from bit sample to symbol; no backpressure, the source paces one byte per 8 clocks.
module conv_encoder_serializer #(
    parameter logic [6:0] G0 = 7'b1011011,
    parameter logic [6:0] G1 = 7'b1111001
) (
    input logic                      clk,
    input logic                      reset_n,
    conv_encoder_serializer_if.slave bus
);
    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] ENCODING = 2'd1;
    localparam logic [1:0] FLUSH    = 2'd2;

    logic [1:0] state;
    logic [2:0] bit_cnt;
    logic [2:0] tail_cnt;
    logic [7:0] byte_reg;
    logic [5:0] enc_state;
    logic       end_pending;

    logic       u;
    logic [6:0] w;
    logic       sym_a;
    logic       sym_b;

    always_comb begin
        u = 1'b0;
        if (state == ENCODING) begin
            u = (bit_cnt == 3'd0) ? bus.din[0] : byte_reg[bit_cnt];
        end
        // History is bit-reversed into the window so tap bit (6-i) lines up with u[n-i].
        w = {u, enc_state[0], enc_state[1], enc_state[2], enc_state[3], enc_state[4], enc_state[5]};
        sym_a = ^(w & G0);
        sym_b = ^(w & G1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state              <= IDLE;
            bit_cnt            <= 3'd0;
            tail_cnt           <= 3'd0;
            byte_reg           <= 8'd0;
            enc_state          <= 6'd0;
            end_pending        <= 1'b0;
            bus.dout           <= 2'd0;
            bus.dout_valid     <= 1'b0;
            bus.next_indicator <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.dout           <= 2'd0;
                    bus.dout_valid     <= 1'b0;
                    bus.next_indicator <= 1'b0;
                    if (bus.indicator) begin
                        state       <= ENCODING;
                        bit_cnt     <= 3'd0;
                        enc_state   <= 6'd0;
                        end_pending <= 1'b0;
                    end
                end
                ENCODING: begin
                    if (bit_cnt == 3'd0) begin
                        byte_reg <= bus.din;
                    end
                    bit_cnt            <= bit_cnt + 3'd1;
                    enc_state          <= {enc_state[4:0], u};
                    bus.dout           <= {sym_a, sym_b};
                    bus.dout_valid     <= 1'b1;
                    bus.next_indicator <= 1'b0;
                    // The end pulse only takes effect on a byte boundary; partial bytes are never dropped.
                    if (bit_cnt == 3'd7) begin
                        if (end_pending || bus.indicator) begin
                            state       <= FLUSH;
                            tail_cnt    <= 3'd0;
                            end_pending <= 1'b0;
                        end
                    end else if (bus.indicator) begin
                        end_pending <= 1'b1;
                    end
                end
                FLUSH: begin
                    bus.dout       <= {sym_a, sym_b};
                    bus.dout_valid <= 1'b1;
                    if (tail_cnt == 3'd5) begin
                        state              <= IDLE;
                        tail_cnt           <= 3'd0;
                        enc_state          <= 6'd0;
                        bus.next_indicator <= 1'b1;
                    end else begin
                        tail_cnt           <= tail_cnt + 3'd1;
                        enc_state          <= {enc_state[4:0], u};
                        bus.next_indicator <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
